wb_master: RTL
==============

// Module: wb_master
//
// PURPOSE
//   Wishbone B4 pipelined initiator. It turns a simple valid/ready request
//   port (from the CPU load/store unit) into single Wishbone transactions
//   towards slaves such as the LED bar. It returns one response pulse per
//   request, carrying read data or an error flag.
//   Only one transaction is outstanding at a time. A bus timeout prevents
//   a silent or unmapped slave from hanging the CPU.
//
// PARAMETERS
//   ADDR_WIDTH  32   Wishbone address width
//   DATA_WIDTH  32   data width; must be a multiple of 8
//   TIMEOUT     255  cycles with o_cyc high before abort; 0 disables timeout
//   (SEL_WIDTH = DATA_WIDTH/8, derived locally)
//
// PORTS
//   i_clk         in   1           system clock; all logic on rising edge
//   i_rst_n       in   1           asynchronous reset, active-low
//   i_req_valid   in   1           request valid
//   o_req_ready   out  1           request accepted when valid && ready
//   i_req_we      in   1           1 = write, 0 = read
//   i_req_addr    in   ADDR_WIDTH  request address
//   i_req_data    in   DATA_WIDTH  write data
//   i_req_sel     in   SEL_WIDTH   byte enables
//   o_rsp_valid   out  1           one-cycle response pulse
//   o_rsp_data    out  DATA_WIDTH  read data (0 for writes and errors)
//   o_rsp_err     out  1           bus error or timeout
//   o_cyc         out  1           Wishbone CYC
//   o_stb         out  1           Wishbone STB
//   o_we          out  1           Wishbone WE
//   o_addr        out  ADDR_WIDTH  Wishbone address
//   o_data        out  DATA_WIDTH  Wishbone write data
//   o_sel         out  SEL_WIDTH   Wishbone byte select
//   i_stall       in   1           slave stall
//   i_ack         in   1           slave acknowledge
//   i_err         in   1           slave error
//   i_data        in   DATA_WIDTH  slave read data
//
// BEHAVIOUR
//   Reset (asynchronous, while i_rst_n = 0):
//     - state = IDLE.
//     - All registered outputs = 0: o_cyc, o_stb, o_we, o_addr, o_data,
//       o_sel, o_rsp_valid, o_rsp_data, o_rsp_err, timeout counter.
//     - o_req_ready = 0 while in reset.
//     - Reset during a transaction drops cyc/stb immediately; no response
//       is issued for that transaction.
//   o_req_ready = (state == IDLE) && i_rst_n. It is combinational.
//   IDLE:
//     - On accept: latch we/addr/data/sel onto the o_* bus registers.
//     - o_cyc = o_stb = 1 on the next cycle; go to REQ.
//     - Clear the timeout counter.
//   REQ (cyc = 1, stb = 1):
//     - Bus fields are held stable while i_stall = 1.
//     - On a cycle with !i_stall: stb = 0 at the next edge; go to WAIT.
//   WAIT (cyc = 1, stb = 0):
//     - Wait for i_ack or i_err.
//   Completion (any cycle with cyc = 1, including REQ with !i_stall):
//     - i_ack: o_rsp_valid = 1 at the next edge.
//       o_rsp_data = i_data for reads, 0 for writes. o_rsp_err = 0.
//     - i_err: same response pulse with o_rsp_err = 1 and o_rsp_data = 0.
//     - i_ack and i_err together: err wins.
//     - At the same edge: cyc = stb = 0 and state = IDLE.
//   Timeout:
//     - The counter increments every cycle cyc = 1 and saturates.
//     - When it reaches TIMEOUT (TIMEOUT != 0) before completion: drop
//       cyc/stb, pulse o_rsp_valid with o_rsp_err = 1, return to IDLE.
//     - A late ack/err after an abort is ignored, because cyc is low.
//   Response port:
//     - o_rsp_valid is high for exactly 1 cycle; there is no backpressure.
//     - o_rsp_data and o_rsp_err hold their value until the next response.
//   Throughput:
//     - o_req_ready is high in the same cycle as o_rsp_valid, so back-to-back
//       requests are allowed.
//     - With a zero-stall slave that acks 1 cycle after stb:
//       accept at T0, stb at T1, ack at T2, rsp_valid at T3.
//   i_req_valid while not ready: ignored; the requester holds the request.
//
// TESTING
//   1. Write addr 0x10, data 0xA5A5, sel 0xF; slave never stalls and acks 1
//      cycle later -> stb high exactly 1 cycle (T1), rsp_valid at T3,
//      rsp_err 0, rsp_data 0.
//   2. Read addr 0x20; i_stall high for 3 cycles; ack with i_data 0x1234 ->
//      stb high 4 cycles with addr stable; rsp_data 0x1234.
//   3. Read; slave asserts i_err and i_ack in the same cycle -> rsp_err 1,
//      rsp_data 0; cyc low on the following cycle.
//   4. TIMEOUT = 8; slave never responds -> cyc high 8 cycles, then drops;
//      rsp_valid with rsp_err 1; a late i_ack is ignored.
//   5. i_rst_n pulled low mid-WAIT -> cyc/stb/rsp_valid go to 0 without a
//      clock edge; no response after release; ready = 1.
//   6. Two requests presented back-to-back (valid held) -> second accepted
//      in the rsp_valid cycle of the first; two responses 3 cycles apart.

Source files
------------

// File: rtl/wb_master.sv
// Wishbone B4 pipelined initiator: turns one valid/ready request into a single
// bus transaction and returns one response pulse, with a bus-timeout abort.
module wb_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_we,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_req_data,
  input  logic [DATA_WIDTH/8-1:0] i_req_sel,
  output logic                    o_rsp_valid,
  output logic [DATA_WIDTH-1:0]   o_rsp_data,
  output logic                    o_rsp_err,
  output logic                    o_cyc,
  output logic                    o_stb,
  output logic                    o_we,
  output logic [ADDR_WIDTH-1:0]   o_addr,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [DATA_WIDTH/8-1:0] o_sel,
  input  logic                    i_stall,
  input  logic                    i_ack,
  input  logic                    i_err,
  input  logic [DATA_WIDTH-1:0]   i_data
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W:0] TO_LIM = (CNT_W + 1)'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                  state_q,     state_d;
  logic                    cyc_q,       cyc_d;
  logic                    stb_q,       stb_d;
  logic                    we_q,        we_d;
  logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
  logic [DATA_WIDTH-1:0]   data_q,      data_d;
  logic [SEL_WIDTH-1:0]    sel_q,       sel_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q,  rsp_data_d;
  logic                    rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0]        cnt_q,       cnt_d;

  logic [CNT_W:0]          cnt_inc;
  logic                    timeout_hit;

  // cnt_inc is the number of cyc cycles elapsed including the current one
  assign cnt_inc     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc >= TO_LIM);

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    sel_d       = sel_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          we_d    = i_req_we;
          addr_d  = i_req_addr;
          data_d  = i_req_data;
          sel_d   = i_req_sel;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        cnt_d = cnt_inc[CNT_W] ? cnt_q : cnt_inc[CNT_W-1:0];
        // Completion outranks a timeout landing on the same cycle; err outranks ack
        if (i_err || i_ack) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = i_err;
          rsp_data_d  = (!i_err && !we_q) ? i_data : '0;
        end else if (timeout_hit) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end else if ((state_q == S_REQ) && !i_stall) begin
          stb_d   = 1'b0;
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_req_ready = (state_q == S_IDLE) && i_rst_n;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_cyc       = cyc_q;
  assign o_stb       = stb_q;
  assign o_we        = we_q;
  assign o_addr      = addr_q;
  assign o_data      = data_q;
  assign o_sel       = sel_q;

endmodule
